// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and tag type for the ALU arbiter
package alu_pkg;

  localparam int ALU_DW  = 8;
  localparam int ALU_RW  = 16;
  localparam int ALU_OPW = 3;
  localparam int ID_MAXW = 2;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] OP_MUL = 3'b010;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'b011;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'b100;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'b101;
  localparam logic [ALU_OPW-1:0] OP_SHL = 3'b110;
  localparam logic [ALU_OPW-1:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
  } rsp_tag_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between the clients and alu_arbiter
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [ALU_DW*NUM_REQ-1:0]  req_a_i;
  logic [ALU_DW*NUM_REQ-1:0]  req_b_i;
  logic [ALU_OPW*NUM_REQ-1:0] req_inst_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [IDW-1:0]             rsp_id_o;
  logic [ALU_RW-1:0]          rsp_data_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - in-order show-ahead response FIFO holding ALU result and requester id
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW   = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ALU_RW-1:0] push_data_i,
  input  logic [IDW-1:0]    push_id_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [ALU_RW-1:0] data_o,
  output logic [IDW-1:0]    id_o,
  output logic [CW-1:0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ALU_RW-1:0] data_mem_q [DEPTH];
  logic [IDW-1:0]    id_mem_q   [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop;

  assign valid_o = (count_q != '0);
  assign pop     = pop_i & valid_o;
  assign count_o = count_q;
  // Outputs read as zero while empty so nothing stale is ever presented.
  assign data_o  = valid_o ? data_mem_q[rd_q] : '0;
  assign id_o    = valid_o ? id_mem_q[rd_q] : '0;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop)    rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({push_i, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      data_mem_q[wr_q] <= push_data_i;
      id_mem_q[wr_q]   <= push_id_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
    !(push_i && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered ALU with tag tracking and response FIFO
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  alu_arbiter_if.slave       bus,
  output logic [ALU_DW-1:0]  alu_a_o,
  output logic [ALU_DW-1:0]  alu_b_o,
  output logic [ALU_OPW-1:0] alu_inst_o,
  input  logic [ALU_RW-1:0]  alu_data_i,
  output logic               busy_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  // Stage 0 travels with the ALU input registers; the remaining ALU_LAT stages cover the ALU.
  localparam int NST = ALU_LAT + 1;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [ALU_DW-1:0]  alu_a_q, alu_a_d;
  logic [ALU_DW-1:0]  alu_b_q, alu_b_d;
  logic [ALU_OPW-1:0] alu_inst_q, alu_inst_d;
  rsp_tag_t           tag_q [NST];
  rsp_tag_t           tag_d [NST];
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] ready;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     cand;
  logic               gnt_found;
  logic               credit_ok;
  logic               hs;
  int                 inflight;
  int                 inflight_nxt;
  logic [CW-1:0]      fifo_count;
  logic               push;
  logic               pop;
  logic               fifo_valid;
  logic [ALU_RW-1:0]  fifo_data;
  logic [IDW-1:0]     fifo_id;
  logic               tag_id_unused;

  always_comb begin
    inflight = 0;
    for (int s = 0; s < NST; s++) inflight += int'(tag_q[s].valid);
  end

  assign credit_ok = (int'(fifo_count) + inflight) < RSP_DEPTH;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'(wrap_idx(int'(ptr_q), i, NUM_REQ));
      if (!gnt_found && bus.req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    ready = '0;
    if (gnt_found && credit_ok && !rst_i) ready[gnt_id] = 1'b1;
  end

  assign hs              = |ready;
  assign bus.req_ready_o = ready;

  always_comb begin
    ptr_d      = ptr_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_inst_d = alu_inst_q;
    tag_d[0]   = '{valid: hs, id: ID_MAXW'(gnt_id)};
    for (int s = 1; s < NST; s++) tag_d[s] = tag_q[s-1];
    if (hs) begin
      ptr_d      = IDW'(wrap_idx(int'(gnt_id), 1, NUM_REQ));
      alu_a_d    = bus.req_a_i[ALU_DW*int'(gnt_id) +: ALU_DW];
      alu_b_d    = bus.req_b_i[ALU_DW*int'(gnt_id) +: ALU_DW];
      alu_inst_d = bus.req_inst_i[ALU_OPW*int'(gnt_id) +: ALU_OPW];
    end
  end

  assign push          = tag_q[NST-1].valid;
  assign pop           = fifo_valid & bus.rsp_ready_i;
  assign tag_id_unused = ^tag_q[NST-1].id;

  // busy reflects the state after the edge, so it is built from next-state counts.
  always_comb begin
    inflight_nxt = int'(hs);
    for (int s = 0; s < NST - 1; s++) inflight_nxt += int'(tag_q[s].valid);
    busy_d = (inflight_nxt != 0) ||
             ((int'(fifo_count) + int'(push) - int'(pop)) != 0);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
      busy_q     <= 1'b0;
      for (int s = 0; s < NST; s++) tag_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_inst_q <= alu_inst_d;
      busy_q     <= busy_d;
      for (int s = 0; s < NST; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_inst_o = alu_inst_q;
  assign busy_o     = busy_q;

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .IDW   (IDW)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (alu_data_i),
    .push_id_i   (tag_q[NST-1].id[IDW-1:0]),
    .pop_i       (bus.rsp_ready_i),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .id_o        (fifo_id),
    .count_o     (fifo_count)
  );

  assign bus.rsp_valid_o = fifo_valid;
  assign bus.rsp_data_o  = fifo_data;
  assign bus.rsp_id_o    = fifo_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench with a queue-based reference model for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int ALU_LAT   = 1;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  alu_a_o, alu_b_o;
  logic [2:0]  alu_inst_o;
  logic [15:0] alu_data = '0;
  logic        busy_o;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  alu_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ALU_LAT   (ALU_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .alu_inst_o (alu_inst_o),
    .alu_data_i (alu_data),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Registered ALU stub: result = {a, b}
  always @(posedge clk) alu_data <= {alu_a_o, alu_b_o};

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } op_t;

  op_t         m_pipe[$];
  op_t         m_fifo[$];
  int          m_ptr = 0;
  int          cyc = 0;
  bit          m_ok = 0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [2:0]  m_inst = '0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          tcyc = 0;
  int          gnt_log[$];
  int          rsp_id_log[$];
  logic [15:0] rsp_data_log[$];
  int          rsp_cyc_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int g;
    op_t op;
    exp_rdy = '0;
    if (m_ok && !rst_i && (m_fifo.size() + m_pipe.size() < RSP_DEPTH)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        g = (m_ptr + i) % NUM_REQ;
        if (bus.req_valid_i[g]) begin
          exp_rdy[g] = 1'b1;
          break;
        end
      end
    end
    if (m_ok) begin
      chk("req_ready", bus.req_ready_o, exp_rdy);
      chk("busy", busy_o, (m_pipe.size() != 0) || (m_fifo.size() != 0));
      chk("rsp_valid", bus.rsp_valid_o, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        chk("rsp_id", bus.rsp_id_o, m_fifo[0].id);
        chk("rsp_data", bus.rsp_data_o, m_fifo[0].data);
      end
      chk("alu_a", alu_a_o, m_a);
      chk("alu_b", alu_b_o, m_b);
      chk("alu_inst", alu_inst_o, m_inst);
    end
    tcyc++;
    for (int k = 0; k < NUM_REQ; k++)
      if (bus.req_valid_i[k] && bus.req_ready_o[k]) gnt_log.push_back(k);
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      rsp_id_log.push_back(int'(bus.rsp_id_o));
      rsp_data_log.push_back(bus.rsp_data_o);
      rsp_cyc_log.push_back(tcyc);
    end
    if (rst_i) begin
      m_pipe.delete();
      m_fifo.delete();
      m_ptr = 0;
      m_a = '0;
      m_b = '0;
      m_inst = '0;
      cyc = 0;
      m_ok = 1;
    end else if (m_ok) begin
      cyc++;
      if (m_fifo.size() != 0 && bus.rsp_ready_i) void'(m_fifo.pop_front());
      while (m_pipe.size() != 0 && m_pipe[0].due == cyc) m_fifo.push_back(m_pipe.pop_front());
      for (int k = 0; k < NUM_REQ; k++) begin
        if (exp_rdy[k]) begin
          op.id   = k;
          op.data = {bus.req_a_i[8*k +: 8], bus.req_b_i[8*k +: 8]};
          op.due  = cyc + ALU_LAT + 1;
          m_pipe.push_back(op);
          m_a    = bus.req_a_i[8*k +: 8];
          m_b    = bus.req_b_i[8*k +: 8];
          m_inst = bus.req_inst_i[3*k +: 3];
          m_ptr  = (k + 1) % NUM_REQ;
        end
      end
    end
  end

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] inst, input logic v);
    bus.req_a_i[8*k +: 8]    = a;
    bus.req_b_i[8*k +: 8]    = b;
    bus.req_inst_i[3*k +: 3] = inst;
    bus.req_valid_i[k]       = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_id_log.delete();
    rsp_data_log.delete();
    rsp_cyc_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  initial begin
    rst_i           = 1'b1;
    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_inst_i  = '0;
    bus.rsp_ready_i = 1'b1;
    step(2);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_alu_a", alu_a_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_rsp_id", bus.rsp_id_o, 0);
    chk("rst_busy", busy_o, 0);
    step(1);
    rst_i = 1'b0;
    step(1);

    // 1: single request from req0
    set_req(0, 8'd25, 8'd35, OP_AND, 1'b1);
    step(1);
    bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("t1_alu_a", alu_a_o, 25);
    chk("t1_alu_inst", alu_inst_o, 3'b011);
    step(2);
    @(negedge clk);
    chk("t1_rsp_valid", bus.rsp_valid_o, 1);
    chk("t1_rsp_id", bus.rsp_id_o, 0);
    chk("t1_rsp_data", bus.rsp_data_o, 16'h1923);
    step(3);

    // 6: req1 alone is granted immediately
    set_req(1, 8'd37, 8'd128, OP_OR, 1'b1);
    @(negedge clk);
    chk("t6_ready", bus.req_ready_o, 2'b10);
    step(1);
    bus.req_valid_i[1] = 1'b0;
    step(2);
    @(negedge clk);
    chk("t6_rsp_valid", bus.rsp_valid_o, 1);
    chk("t6_rsp_id", bus.rsp_id_o, 1);
    chk("t6_rsp_data", bus.rsp_data_o, 16'h2580);
    step(3);

    // 2: both requesting, full throughput
    clear_logs();
    set_req(0, 8'h11, 8'h22, OP_ADD, 1'b1);
    set_req(1, 8'h33, 8'h44, OP_SUB, 1'b1);
    step(8);
    bus.req_valid_i = '0;
    step(6);
    chk("t2_gnt_count", gnt_log.size(), 8);
    chk("t2_rsp_count", rsp_id_log.size(), 8);
    if (gnt_log.size() == 8 && rsp_id_log.size() == 8) begin
      for (int i = 0; i < 4; i++) chk("t2_gnt", gnt_log[i], i % 2);
      for (int i = 0; i < 4; i++) chk("t2_rsp_id", rsp_id_log[i], i % 2);
      chk("t2_rsp_data0", rsp_data_log[0], 16'h1122);
      for (int i = 1; i < 8; i++) chk("t2_rsp_gap", rsp_cyc_log[i] - rsp_cyc_log[i-1], 1);
    end

    // 3: responses stalled, credit runs out after RSP_DEPTH issues
    clear_logs();
    bus.rsp_ready_i = 1'b0;
    set_req(0, 8'h01, 8'h02, OP_XOR, 1'b1);
    set_req(1, 8'h03, 8'h04, OP_SHL, 1'b1);
    step(8);
    chk("t3_gnt_count", gnt_log.size(), 4);
    @(negedge clk);
    chk("t3_ready_zero", bus.req_ready_o, 0);
    step(1);
    bus.rsp_ready_i = 1'b1;
    step(12);
    bus.req_valid_i = '0;
    step(8);
    chk("t3_resumed", gnt_log.size() > 4, 1);
    if (gnt_log.size() >= 4 && rsp_data_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_gnt_order", gnt_log[i], i % 2);
      for (int i = 0; i < 4; i++)
        chk("t3_rsp_data", rsp_data_log[i], (i % 2) ? 16'h0304 : 16'h0102);
    end

    // 4: FIFO 3 + 1 in flight, pop in the same cycle gives no credit yet
    clear_logs();
    bus.rsp_ready_i = 1'b0;
    set_req(0, 8'd5, 8'd6, OP_MUL, 1'b1);
    step(5);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_no_grant", bus.req_ready_o, 0);
    step(1);
    @(negedge clk);
    chk("t4_grant_next", bus.req_ready_o, 2'b01);
    step(1);
    bus.req_valid_i = '0;
    step(8);

    // 5: reset with two ops in flight
    set_req(0, 8'hA0, 8'hA1, OP_SHR, 1'b1);
    set_req(1, 8'hB0, 8'hB1, OP_SHR, 1'b1);
    step(2);
    bus.req_valid_i = '0;
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("t5_rsp_valid", bus.rsp_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    step(6);
    chk("t5_no_stale", rsp_id_log.size(), 0);
    bus.req_valid_i = 2'b11;
    step(1);
    bus.req_valid_i = '0;
    chk("t5_gnt_seen", gnt_log.size(), 1);
    if (gnt_log.size() != 0) chk("t5_first_gnt", gnt_log[0], 0);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
